parking_gate_controller: RTL

//  Parametrised, clocked successor to the combinational entry check. Tracks the occupancy of NUM_SLOTS bays.

---
 rtl/parking_gate_controller_pkg.sv | 16 +
 rtl/parking_gate_controller_if.sv | 31 +++
 rtl/parking_gate_controller_lowest_free_finder.sv | 22 ++
 rtl/parking_gate_controller.sv | 118 +++++++++++
 4 files changed

// File: rtl/parking_gate_controller_pkg.sv
// Shared types and helpers for the parking gate controller: gate FSM encoding
// and the sizing rule for the gate-open counter.
package parking_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    OPEN     = 2'd1,
    WAIT_REL = 2'd2
  } gate_state_e;

  // The counter only ever holds GATE_OPEN_CYCLES-1 down to 0; keep at least one bit.
  function automatic int gate_cnt_width(input int cycles);
    return (cycles <= 2) ? 1 : $clog2(cycles);
  endfunction

endpackage

// File: rtl/parking_gate_controller_if.sv
// Sensor/actuator bundle between the lane hardware (master) and the controller (slave).
interface parking_gate_controller_if #(
  parameter int NUM_SLOTS = 8
);
  localparam int SLOT_W = $clog2(NUM_SLOTS);

  logic                 entry_req;
  logic                 exit_req;
  logic [SLOT_W-1:0]    exit_slot;
  logic                 entry_grant;
  logic                 entry_deny;
  logic [SLOT_W-1:0]    entry_slot;
  logic                 gate_open;
  logic                 exit_err;
  logic [NUM_SLOTS-1:0] parking_capacity;
  logic [SLOT_W:0]      free_count;
  logic                 full;
  logic                 empty;

  modport master (
    output entry_req, exit_req, exit_slot,
    input  entry_grant, entry_deny, entry_slot, gate_open, exit_err,
           parking_capacity, free_count, full, empty
  );

  modport slave (
    input  entry_req, exit_req, exit_slot,
    output entry_grant, entry_deny, entry_slot, gate_open, exit_err,
           parking_capacity, free_count, full, empty
  );
endinterface

// File: rtl/parking_gate_controller_lowest_free_finder.sv
// Combinational priority encoder: index of the lowest set bit of the free bitmap.
module lowest_free_finder #(
  parameter int NUM_SLOTS = 8,
  localparam int SLOT_W   = $clog2(NUM_SLOTS)
) (
  input  logic [NUM_SLOTS-1:0] bitmap_i,
  output logic [SLOT_W-1:0]    idx_o,
  output logic                 any_free_o
);

  // NOTE: combinational logic uses blocking '='; defaulting idx_o first
  // guarantees every path assigns it, so no latch is inferred.
  always_comb begin
    idx_o = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (bitmap_i[i]) idx_o = SLOT_W'(i);
    end
  end

  assign any_free_o = |bitmap_i;

endmodule

// File: rtl/parking_gate_controller.sv
// Parking entry/exit controller: bay occupancy bitmap, lowest-free allocation,
// request/grant handshake and a timed barrier-open window.
module parking_gate_controller
  import parking_pkg::*;
#(
  parameter int NUM_SLOTS        = 8,
  parameter int GATE_OPEN_CYCLES = 50,
  localparam int SLOT_W          = $clog2(NUM_SLOTS)
) (
  input  logic                         clk,
  input  logic                         reset,
  parking_gate_controller_if.slave     bus
);

  localparam int              CNT_W    = gate_cnt_width(GATE_OPEN_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(GATE_OPEN_CYCLES - 1);
  localparam logic [SLOT_W:0]  ALL_FREE = (SLOT_W + 1)'(NUM_SLOTS);

  gate_state_e          state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [NUM_SLOTS-1:0] cap_q, cap_d;
  logic [SLOT_W:0]      count_q, count_d;
  logic                 full_q, empty_q;
  logic                 grant_q, deny_q, err_q, gate_q;
  logic [SLOT_W-1:0]    slot_q;

  logic [SLOT_W-1:0]    free_idx;
  logic                 any_free;
  logic                 exit_in_range, exit_ok, alloc;

  lowest_free_finder #(.NUM_SLOTS(NUM_SLOTS)) u_finder (
    .bitmap_i   (cap_q),
    .idx_o      (free_idx),
    .any_free_o (any_free)
  );

  // Widen before comparing so non-power-of-two lots still reject the unused codes.
  assign exit_in_range = (32'(bus.exit_slot) < 32'(NUM_SLOTS));
  assign exit_ok       = bus.exit_req && exit_in_range && !cap_q[bus.exit_slot];
  assign alloc         = (state_q == IDLE) && bus.entry_req && any_free;

  // Allocation clears a free bit, exit sets an occupied bit: never the same bit.
  always_comb begin
    cap_d = cap_q;
    if (alloc)   cap_d[free_idx]      = 1'b0;
    if (exit_ok) cap_d[bus.exit_slot] = 1'b1;
    count_d = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      count_d = count_d + {{SLOT_W{1'b0}}, cap_d[i]};
    end
  end

  // NOTE: sequential state uses non-blocking '<=' only, and the bay bitmap is
  // a real reset target: reset must forget every allocation.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cap_q   <= '1;
      count_q <= ALL_FREE;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      grant_q <= 1'b0;
      deny_q  <= 1'b0;
      err_q   <= 1'b0;
      gate_q  <= 1'b0;
      slot_q  <= '0;
    end else begin
      grant_q <= 1'b0;
      deny_q  <= 1'b0;
      err_q   <= bus.exit_req && !exit_ok;
      cap_q   <= cap_d;
      count_q <= count_d;
      full_q  <= (count_d == '0);
      empty_q <= (count_d == ALL_FREE);

      unique case (state_q)
        IDLE: begin
          if (bus.entry_req) begin
            if (any_free) begin
              grant_q <= 1'b1;
              slot_q  <= free_idx;
              gate_q  <= 1'b1;
              cnt_q   <= CNT_LOAD;
              state_q <= OPEN;
            end else begin
              deny_q  <= 1'b1;
              state_q <= WAIT_REL;
            end
          end
        end
        OPEN: begin
          if (cnt_q == '0) begin
            gate_q  <= 1'b0;
            state_q <= WAIT_REL;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        WAIT_REL: begin
          if (!bus.entry_req) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.entry_grant      = grant_q;
  assign bus.entry_deny       = deny_q;
  assign bus.entry_slot       = slot_q;
  assign bus.gate_open        = gate_q;
  assign bus.exit_err         = err_q;
  assign bus.parking_capacity = cap_q;
  assign bus.free_count       = count_q;
  assign bus.full             = full_q;
  assign bus.empty            = empty_q;

endmodule
